// File: rtl/c1_wait_pkg.sv
// rtl/c1_wait_pkg.sv - shared state type and sizing helpers for the 68K wait-state generator
package c1_wait_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXT,
    ST_ACK,
    ST_ERR
  } wait_state_t;

  // Zone index width; the extra code NUM_ZONES means "no zone / unmapped".
  function automatic int idx_w(input int num_zones);
    return $clog2(num_zones + 1);
  endfunction

  function automatic int timeout_w(input int timeout_cyc);
    return $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/c1_zone_prio.sv
// rtl/c1_zone_prio.sv - priority encoder of active-low zone selects plus per-zone wait/ext mux
module c1_zone_prio
  import c1_wait_pkg::*;
#(
  parameter int NUM_ZONES     = 4,
  parameter int CNT_W         = 4,
  parameter int UNMAPPED_WAIT = 0,
  parameter bit UNMAPPED_EXT  = 1'b0,
  parameter int IDX_W         = idx_w(NUM_ZONES)
) (
  input  logic [NUM_ZONES-1:0]       nZONE,
  input  logic [NUM_ZONES*CNT_W-1:0] WAIT_CFG,
  input  logic [NUM_ZONES-1:0]       EXT_EN,
  output logic [IDX_W-1:0]           zone_idx,
  output logic [CNT_W-1:0]           zone_wait,
  output logic                       zone_ext
);

  // Scan from the top so the lowest active index is the one left standing.
  always_comb begin
    zone_idx  = IDX_W'(NUM_ZONES);
    zone_wait = CNT_W'(UNMAPPED_WAIT);
    zone_ext  = UNMAPPED_EXT;
    for (int z = NUM_ZONES - 1; z >= 0; z--) begin
      if (!nZONE[z]) begin
        zone_idx  = IDX_W'(z);
        zone_wait = WAIT_CFG[z*CNT_W +: CNT_W];
        zone_ext  = EXT_EN[z];
      end
    end
  end

endmodule

// File: rtl/c1_wait_gen.sv
// rtl/c1_wait_gen.sv - 68K DTACK wait-state generator for N decoded zones
// C1_WAIT_BERR_EN enables the bus-error watchdog (nBERR); otherwise nBERR is tied high.
module c1_wait_gen
  import c1_wait_pkg::*;
#(
  parameter int NUM_ZONES    = 4,
  parameter int CNT_W        = 4,
  parameter int DEFAULT_WAIT = 0,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                          CLK_68KCLK,
  input  logic                          RESET,
  input  logic                          nAS,
  input  logic [NUM_ZONES-1:0]          nZONE,
  input  logic [NUM_ZONES*CNT_W-1:0]    WAIT_CFG,
  input  logic [NUM_ZONES-1:0]          EXT_EN,
  input  logic                          PDTACK,
  output logic                          nDTACK,
  output logic                          nBERR,
  output logic [idx_w(NUM_ZONES)-1:0]   ACT_ZONE,
  output logic                          BUSY
);

  localparam int IDX_W = idx_w(NUM_ZONES);

`ifdef C1_WAIT_BERR_EN
  localparam bit UNMAPPED_EXT  = 1'b1;
  localparam int UNMAPPED_WAIT = 0;
`else
  localparam bit UNMAPPED_EXT  = 1'b0;
  localparam int UNMAPPED_WAIT = DEFAULT_WAIT;
`endif

  wait_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ext_q, ext_nxt;
  logic [IDX_W-1:0] zone_q, zone_nxt;
  logic [IDX_W-1:0] pick_idx;
  logic [CNT_W-1:0] pick_wait;
  logic             pick_ext;
  logic             bypass;
  logic             wd_hit;

  c1_zone_prio #(
    .NUM_ZONES    (NUM_ZONES),
    .CNT_W        (CNT_W),
    .UNMAPPED_WAIT(UNMAPPED_WAIT),
    .UNMAPPED_EXT (UNMAPPED_EXT),
    .IDX_W        (IDX_W)
  ) u_prio (
    .nZONE    (nZONE),
    .WAIT_CFG (WAIT_CFG),
    .EXT_EN   (EXT_EN),
    .zone_idx (pick_idx),
    .zone_wait(pick_wait),
    .zone_ext (pick_ext)
  );

`ifdef C1_WAIT_BERR_EN
  localparam int WD_W = timeout_w(TIMEOUT_CYC);
  logic [WD_W-1:0] wd;
  logic            berr_n_q;

  // Counts edges spent in WAIT/EXT since capture; hit fires on the edge that reaches the limit.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET || state == ST_IDLE) wd <= '0;
    else if (state == ST_WAIT || state == ST_EXT) wd <= wd + WD_W'(1);
  end

  assign wd_hit = (wd == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) berr_n_q <= 1'b1;
    else       berr_n_q <= (state_nxt != ST_ERR);
  end

  assign nBERR = berr_n_q;
`else
  assign wd_hit = 1'b0;
  assign nBERR  = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ext_nxt   = ext_q;
    zone_nxt  = zone_q;
    case (state)
      ST_IDLE: begin
        if (!nAS) begin
          zone_nxt = pick_idx;
          cnt_nxt  = pick_wait;
          ext_nxt  = pick_ext;
          if (pick_wait != '0) state_nxt = ST_WAIT;
          else if (pick_ext)   state_nxt = ST_EXT;
          else                 state_nxt = ST_ACK;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = ext_q ? ST_EXT : ST_ACK;
        else if (wd_hit)      state_nxt = ST_ERR;
      end
      ST_EXT: begin
        if (PDTACK)      state_nxt = ST_ACK;
        else if (wd_hit) state_nxt = ST_ERR;
      end
      ST_ACK, ST_ERR: ;
      default: state_nxt = ST_IDLE;
    endcase
    // Strobe release ends any captured cycle; zone stays latched for debug.
    if (state != ST_IDLE && nAS) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      ext_q  <= 1'b0;
      zone_q <= IDX_W'(NUM_ZONES);
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      ext_q  <= ext_nxt;
      zone_q <= zone_nxt;
    end
  end

  // Zero-wait zones acknowledge straight off nAS, before the capture edge.
  assign bypass   = (state == ST_IDLE) && (pick_wait == '0) && !pick_ext;
  assign nDTACK   = nAS | RESET | ~((state == ST_ACK) | bypass);
  assign ACT_ZONE = zone_q;
  assign BUSY     = (state != ST_IDLE);

endmodule
